// File: rtl/input_conditioner_array_pkg.sv
// Shared defaults and per-channel output record for the input conditioner array.
// Latency and backpressure are defined by the modules that import this package.
package input_conditioner_array_pkg;

   localparam int DEF_CHANNELS     = 4;
   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_COUNTERWIDTH = 3;
   localparam int DEF_WAITTIME     = 3;
   localparam int DEF_HOLDWIDTH    = 8;
   localparam int DEF_HOLDTIME     = 200;

   typedef struct packed {
      logic conditioned;
      logic positiveedge;
      logic negativeedge;
      logic held;
   } chan_out_t;

endpackage

// File: rtl/input_conditioner_array_if.sv
// Pad-side inputs and conditioned outputs of the array, one bit per channel.
// Latency: none (wiring only); backpressure: none, levels and pulses only.
interface input_conditioner_array_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] noisysignal;
   logic [CHANNELS-1:0] invert;
   logic [CHANNELS-1:0] conditioned;
   logic [CHANNELS-1:0] positiveedge;
   logic [CHANNELS-1:0] negativeedge;
   logic [CHANNELS-1:0] held;
   logic                anyedge;

   modport master (
      output noisysignal, invert,
      input  conditioned, positiveedge, negativeedge, held, anyedge
   );

   modport slave (
      input  noisysignal, invert,
      output conditioned, positiveedge, negativeedge, held, anyedge
   );
endinterface

// File: rtl/input_conditioner_array_channel.sv
// One channel: synchroniser, debounce, 1-clk edge pulses and long-press held flag.
// Latency SYNC_STAGES+WAITTIME clks from capture to output; no backpressure.
module input_conditioner_array_channel
   import input_conditioner_array_pkg::*;
#(
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int COUNTERWIDTH = DEF_COUNTERWIDTH,
   parameter int WAITTIME     = DEF_WAITTIME,
   parameter int HOLDWIDTH    = DEF_HOLDWIDTH,
   parameter int HOLDTIME     = DEF_HOLDTIME
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      noisysignal,
   input  logic      invert,
   output chan_out_t q
);
   localparam logic [COUNTERWIDTH-1:0] WAIT_C = COUNTERWIDTH'(WAITTIME);
   localparam logic [HOLDWIDTH-1:0]    HOLD_C = HOLDWIDTH'(HOLDTIME);

   logic [SYNC_STAGES-1:0]  sync;
   logic [COUNTERWIDTH-1:0] cnt;
   logic [HOLDWIDTH-1:0]    holdcnt;
   logic                    s;
   logic                    falling;

   // Polarity is applied after the synchroniser so a change of invert debounces like any input change.
   assign s       = sync[SYNC_STAGES-1] ^ invert;
   assign falling = (s != q.conditioned) && (cnt == WAIT_C) && !s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync    <= '0;
         cnt     <= '0;
         holdcnt <= '0;
         q       <= '0;
      end else begin
         sync           <= {sync[SYNC_STAGES-2:0], noisysignal};
         q.positiveedge <= 1'b0;
         q.negativeedge <= 1'b0;

         if (s == q.conditioned) begin
            cnt <= '0;
         end else if (cnt == WAIT_C) begin
            cnt            <= '0;
            q.conditioned  <= s;
            q.positiveedge <= s;
            q.negativeedge <= !s;
         end else begin
            cnt <= cnt + 1'b1;
         end

         // held must drop on the very edge that drops conditioned, hence the look-ahead on falling.
         if (falling || !q.conditioned) begin
            holdcnt <= '0;
            q.held  <= 1'b0;
         end else if (!q.held) begin
            if (holdcnt == HOLD_C) begin
               q.held <= 1'b1;
            end else begin
               holdcnt <= holdcnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/input_conditioner_array.sv
// Array of independent input conditioners plus the aggregate anyedge interrupt/wake line.
// Latency SYNC_STAGES+WAITTIME clks per channel, anyedge adds none; no backpressure.
module input_conditioner_array
   import input_conditioner_array_pkg::*;
#(
   parameter int CHANNELS     = DEF_CHANNELS,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int COUNTERWIDTH = DEF_COUNTERWIDTH,
   parameter int WAITTIME     = DEF_WAITTIME,
   parameter int HOLDWIDTH    = DEF_HOLDWIDTH,
   parameter int HOLDTIME     = DEF_HOLDTIME
) (
   input logic                        clk,
   input logic                        rst_n,
   input_conditioner_array_if.slave   bus
);
   logic [CHANNELS-1:0] cond;
   logic [CHANNELS-1:0] pos;
   logic [CHANNELS-1:0] neg;
   logic [CHANNELS-1:0] hld;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      chan_out_t o;

      input_conditioner_array_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .COUNTERWIDTH (COUNTERWIDTH),
         .WAITTIME     (WAITTIME),
         .HOLDWIDTH    (HOLDWIDTH),
         .HOLDTIME     (HOLDTIME)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .noisysignal (bus.noisysignal[i]),
         .invert      (bus.invert[i]),
         .q           (o)
      );

      assign cond[i] = o.conditioned;
      assign pos[i]  = o.positiveedge;
      assign neg[i]  = o.negativeedge;
      assign hld[i]  = o.held;
   end

   assign bus.conditioned  = cond;
   assign bus.positiveedge = pos;
   assign bus.negativeedge = neg;
   assign bus.held         = hld;
   // Pulses are already registered, so the OR keeps anyedge in the same cycle as them.
   assign bus.anyedge      = |(pos | neg);
endmodule
